// File: rtl/data8out_pkg.sv
// Shared types and sizing constants for the data8out arbiter.
package data8out_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    GUARD = 2'd2,
    WAIT  = 2'd3
  } state_t;

  localparam int DEF_WIDTH = 40;
  localparam int BYTES     = DEF_WIDTH / 8;

endpackage

// File: rtl/data8out_arbiter_if.sv
// Requester-side and serializer-side signals of the data8out arbiter.
interface data8out_arbiter_if
  import data8out_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = DEF_WIDTH
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] din;
  logic [NREQ-1:0]       ack;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      ser_din;
  logic                  ser_load;
  logic                  ser_ready;
  logic [IW-1:0]         owner;
  logic                  busy;
  logic                  err;

  modport slave (
    input  req, din, ser_ready,
    output ack, done, ser_din, ser_load, owner, busy, err
  );

  modport master (
    output req, din, ser_ready,
    input  ack, done, ser_din, ser_load, owner, busy, err
  );
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after last+1, with wrap.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic            valid,
  output logic [IW-1:0]   g
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  int                base;
  int                pos;
  int                sum;

  always_comb begin
    base = int'(last) + 1;
    if (base >= NREQ) base = 0;
    // Rotate so bit 0 of rot is requester last+1, then take the lowest set bit.
    dbl = {req, req} >> base;
    rot = dbl[NREQ-1:0];
    pos = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) pos = k;
    end
    sum = base + pos;
    if (sum >= NREQ) sum = sum - NREQ;
    valid = |req;
    g     = IW'(sum);
  end

endmodule

// File: rtl/data8out_arbiter.sv
// Round-robin arbiter that feeds one data8out serializer from NREQ requesters.
module data8out_arbiter
  import data8out_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = 64
) (
  input logic               pclk,
  input logic               rst_n,
  data8out_arbiter_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT);

  logic [WIDTH-1:0] word [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_word
      assign word[gi] = bus.din[gi*WIDTH +: WIDTH];
    end
  endgenerate

  state_t           state_q, state_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic [WIDTH-1:0] ser_din_q, ser_din_d;
  logic             ser_load_q, ser_load_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    last_q, last_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic [TW-1:0]    timer_q, timer_d;

  logic             pick_valid;
  logic [IW-1:0]    pick_g;

  rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req   (bus.req),
    .last  (last_q),
    .valid (pick_valid),
    .g     (pick_g)
  );

  always_comb begin
    state_d    = state_q;
    ack_d      = '0;
    done_d     = '0;
    ser_load_d = 1'b0;
    ser_din_d  = ser_din_q;
    owner_d    = owner_q;
    last_d     = last_q;
    err_d      = err_q;
    timer_d    = timer_q;
    case (state_q)
      IDLE: begin
        if (bus.ser_ready && pick_valid) begin
          ser_din_d      = word[pick_g];
          owner_d        = pick_g;
          ack_d[pick_g]  = 1'b1;
          ser_load_d     = 1'b1;
          state_d        = LOAD;
        end
      end
      LOAD: state_d = GUARD;
      GUARD: begin
        // The serializer may still report ready here; it is deliberately ignored.
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + TW'(1);
        if (bus.ser_ready) begin
          done_d[owner_q] = 1'b1;
          last_d          = owner_q;
          state_d         = IDLE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          last_d  = owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ack_q      <= '0;
      done_q     <= '0;
      ser_din_q  <= '0;
      ser_load_q <= 1'b0;
      owner_q    <= '0;
      last_q     <= IW'(NREQ - 1);
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      ser_din_q  <= ser_din_d;
      ser_load_q <= ser_load_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      timer_q    <= timer_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.done     = done_q;
  assign bus.ser_din  = ser_din_q;
  assign bus.ser_load = ser_load_q;
  assign bus.owner    = owner_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_data8out_arbiter.sv
// Directed self-checking bench for data8out_arbiter with a simple serializer ready model.
module tb_data8out_arbiter;

  localparam int NREQ    = 4;
  localparam int WIDTH   = 40;
  localparam int TIMEOUT = 64;

  logic pclk  = 1'b0;
  logic rst_n = 1'b0;
  always #5 pclk = ~pclk;

  data8out_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  data8out_arbiter #(
    .NREQ    (NREQ),
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .pclk  (pclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Serializer model: ready drops the cycle after load and returns 5 cycles later.
  logic mdl_rdy;
  int   mdl_cnt;
  logic stuck    = 1'b0;
  logic gate_low = 1'b0;
  assign bus.ser_ready = mdl_rdy & ~gate_low;

  always @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_rdy <= 1'b1;
      mdl_cnt <= 0;
    end else if (bus.ser_load) begin
      mdl_rdy <= 1'b0;
      mdl_cnt <= 5;
    end else if (mdl_cnt == 1 && !stuck) begin
      mdl_rdy <= 1'b1;
      mdl_cnt <= 0;
    end else if (mdl_cnt > 1) begin
      mdl_cnt <= mdl_cnt - 1;
    end
  end

  int total = 0;
  int bad   = 0;
  int ack_cnt  [NREQ] = '{default: 0};
  int done_cnt [NREQ] = '{default: 0};
  int a_snap   [NREQ] = '{default: 0};
  int d_snap   [NREQ] = '{default: 0};
  int overlap = 0;

  always @(posedge pclk) begin
    #1;
    if (rst_n) begin
      for (int k = 0; k < NREQ; k++) begin
        if (bus.ack[k])  ack_cnt[k]++;
        if (bus.done[k]) done_cnt[k]++;
      end
      if (bus.ack != '0 && bus.done != '0) overlap++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end else begin
      $display("check %s ok (%0h)", tag, got);
    end
  endtask

  function automatic logic [39:0] wrd(input int tag, input int k);
    return {8'(tag), 8'(k), 24'hC0FFEE};
  endfunction

  task automatic set_word(input int i, input logic [39:0] w);
    bus.din[i*WIDTH +: WIDTH] = w;
  endtask

  task automatic snap();
    for (int k = 0; k < NREQ; k++) begin
      a_snap[k] = ack_cnt[k];
      d_snap[k] = done_cnt[k];
    end
  endtask

  // which: 0 = any ack, 1 = any done, 2 = err
  task automatic wait_evt(input int which, input int budget, output int cyc);
    logic hit;
    hit = 1'b0;
    cyc = 0;
    while (!hit && cyc < budget) begin
      @(negedge pclk);
      cyc++;
      case (which)
        0:       hit = (bus.ack != '0);
        1:       hit = (bus.done != '0);
        default: hit = bus.err;
      endcase
    end
    chk($sformatf("seen_evt%0d", which), 64'(hit), 64'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge pclk);
    rst_n = 1'b1;
    @(negedge pclk);
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_ack"},  64'(bus.ack),      64'd0);
    chk({pfx, "_done"}, 64'(bus.done),     64'd0);
    chk({pfx, "_din"},  64'(bus.ser_din),  64'd0);
    chk({pfx, "_load"}, 64'(bus.ser_load), 64'd0);
    chk({pfx, "_own"},  64'(bus.owner),    64'd0);
    chk({pfx, "_busy"}, 64'(bus.busy),     64'd0);
    chk({pfx, "_err"},  64'(bus.err),      64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int seq [4] = '{0, 2, 0, 2};
    int e;
    int dsum;

    bus.req = '0;
    bus.din = '0;
    repeat (2) @(negedge pclk);
    chk_zero("rst");
    rst_n = 1'b1;
    @(negedge pclk);

    // Single request on requester 1
    set_word(1, 40'h1255667890);
    bus.req = 4'b0010;
    @(negedge pclk);
    chk("t1_ack",   64'(bus.ack),      64'h2);
    chk("t1_load",  64'(bus.ser_load), 64'd1);
    chk("t1_din",   64'(bus.ser_din),  64'h1255667890);
    chk("t1_owner", 64'(bus.owner),    64'd1);
    chk("t1_busy",  64'(bus.busy),     64'd1);
    bus.req = '0;
    @(negedge pclk);
    chk("t1_ack_1cyc",  64'(bus.ack),      64'd0);
    chk("t1_load_1cyc", 64'(bus.ser_load), 64'd0);
    chk("t1_busy_mid",  64'(bus.busy),     64'd1);
    wait_evt(1, 50, cyc);
    // load at L, ready back at L+6, done at L+7
    chk("t1_done_lat",  64'(cyc + 1),      64'd7);
    chk("t1_done",      64'(bus.done),     64'h2);
    chk("t1_idle",      64'(bus.busy),     64'd0);
    chk("t1_din_hold",  64'(bus.ser_din),  64'h1255667890);
    @(negedge pclk);
    chk("t1_done_1cyc", 64'(bus.done),     64'd0);

    // All four at once after reset: order 0,1,2,3
    do_reset();
    snap();
    for (int k = 0; k < NREQ; k++) set_word(k, wrd(3, k));
    bus.req = 4'b1111;
    for (int k = 0; k < NREQ; k++) begin
      wait_evt(0, 40, cyc);
      chk($sformatf("t3_ack%0d", k),   64'(bus.ack),     64'(1 << k));
      chk($sformatf("t3_din%0d", k),   64'(bus.ser_din), 64'(wrd(3, k)));
      chk($sformatf("t3_own%0d", k),   64'(bus.owner),   64'(k));
      bus.req[k] = 1'b0;
      wait_evt(1, 40, cyc);
      chk($sformatf("t3_done%0d", k),  64'(bus.done),    64'(1 << k));
    end
    @(negedge pclk);
    for (int k = 0; k < NREQ; k++) begin
      chk($sformatf("t3_nack%0d", k),  64'(ack_cnt[k] - a_snap[k]),  64'd1);
      chk($sformatf("t3_ndone%0d", k), 64'(done_cnt[k] - d_snap[k]), 64'd1);
    end

    // Fairness between requesters 0 and 2
    snap();
    set_word(0, wrd(4, 0));
    set_word(2, wrd(4, 1));
    bus.req = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      e = seq[i];
      wait_evt(0, 40, cyc);
      chk($sformatf("t4_ack%0d", i), 64'(bus.ack),     64'(1 << e));
      chk($sformatf("t4_din%0d", i), 64'(bus.ser_din), 64'(wrd(4, i)));
      bus.req[e] = 1'b0;
      @(negedge pclk);
      if (i < 2) begin
        set_word(e, wrd(4, i + 2));
        bus.req[e] = 1'b1;
      end
      wait_evt(1, 40, cyc);
      chk($sformatf("t4_done%0d", i), 64'(bus.done), 64'(1 << e));
    end
    chk("t4_never1", 64'(ack_cnt[1] - a_snap[1]), 64'd0);
    chk("t4_never3", 64'(ack_cnt[3] - a_snap[3]), 64'd0);

    // Timeout with ready stuck low
    stuck = 1'b1;
    set_word(1, wrd(5, 1));
    bus.req = 4'b0010;
    wait_evt(0, 40, cyc);
    chk("t5_ack", 64'(bus.ack), 64'h2);
    bus.req = '0;
    snap();
    wait_evt(2, 100, cyc);
    // WAIT entered at L+2, err visible 64 cycles later
    chk("t5_err_lat", 64'(cyc),      64'd66);
    chk("t5_err",     64'(bus.err),  64'd1);
    chk("t5_idle",    64'(bus.busy), 64'd0);
    dsum = 0;
    for (int k = 0; k < NREQ; k++) dsum += done_cnt[k] - d_snap[k];
    chk("t5_no_done", 64'(dsum), 64'd0);
    set_word(3, wrd(5, 3));
    bus.req = 4'b1000;
    snap();
    repeat (10) @(negedge pclk);
    chk("t5_no_grant", 64'(ack_cnt[3] - a_snap[3]), 64'd0);
    chk("t5_err_stk",  64'(bus.err),                64'd1);

    // Reset in the middle of a transfer
    stuck = 1'b0;
    wait_evt(0, 40, cyc);
    chk("t6_ack3", 64'(bus.ack), 64'h8);
    bus.req = '0;
    repeat (3) @(negedge pclk);
    chk("t6_busy", 64'(bus.busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("t6_rst");
    @(negedge pclk);
    @(negedge pclk);
    rst_n = 1'b1;
    set_word(0, wrd(6, 0));
    set_word(3, wrd(6, 3));
    bus.req = 4'b1001;
    wait_evt(0, 40, cyc);
    chk("t6_first", 64'(bus.ack), 64'h1);
    bus.req[0] = 1'b0;
    wait_evt(1, 40, cyc);
    chk("t6_done0", 64'(bus.done), 64'h1);
    wait_evt(0, 40, cyc);
    chk("t6_second", 64'(bus.ack),     64'h8);
    chk("t6_din3",   64'(bus.ser_din), 64'(wrd(6, 3)));
    bus.req[3] = 1'b0;
    wait_evt(1, 40, cyc);
    chk("t6_done3", 64'(bus.done), 64'h8);

    // Ready gating in IDLE
    gate_low = 1'b1;
    set_word(2, wrd(7, 2));
    bus.req = 4'b0100;
    snap();
    repeat (5) @(negedge pclk);
    chk("t7_held",   64'(ack_cnt[2] - a_snap[2]), 64'd0);
    chk("t7_noack",  64'(bus.ack),                64'd0);
    gate_low = 1'b0;
    @(negedge pclk);
    chk("t7_ack",    64'(bus.ack),     64'h4);
    chk("t7_din",    64'(bus.ser_din), 64'(wrd(7, 2)));
    bus.req = '0;
    wait_evt(1, 40, cyc);
    chk("t7_done",   64'(bus.done),    64'h4);

    chk("ack_done_overlap", 64'(overlap), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data8out_arbiter.md
# data8out_arbiter

Round-robin arbiter and sequencer sharing one `data8out` byte serializer among `NREQ` requesters. Each requester presents a `WIDTH`-bit word. The arbiter grants one requester at a time, loads the word into the serializer with a single-cycle load pulse, then waits for the serializer to finish. It sits between the pixel-side producers and the serializer's `din` / `inputReady` / `ready` ports.

## Interface
- `NREQ`, 4, number of requesters (2..8).
- `WIDTH`, 40, word width; equals serializer `din` width.
- `TIMEOUT`, 64, maximum WAIT cycles before an error is declared (≥4).

- `pclk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req`  in  NREQ  per-requester request level; held with data until ack.
- `din`  in  NREQ*WIDTH  flattened words; requester i occupies bits [i*WIDTH +: WIDTH].
- `ack`  out  NREQ  one-cycle pulse: word i captured.
- `done`  out  NREQ  one-cycle pulse: word i fully serialized.
- `ser_din`  out  WIDTH  word to serializer; drives `din`.
- `ser_load`  out  1  one-cycle load pulse; drives `inputReady`.
- `ser_ready`  in  1  serializer idle (from `ready`).
- `owner`  out  clog2(NREQ)  index of current/last grant.
- `busy`  out  1  high in LOAD, GUARD and WAIT.
- `err`  out  1  sticky timeout flag, cleared only by reset.

## Operation
- States: IDLE, LOAD, GUARD, WAIT.
- **IDLE:** if `ser_ready`=1 and any `req` is set, select the grant `g` by round-robin, searching from `last+1` upward with wrap.
  - On the clock edge: `ser_din`<=`din[g]`, `owner`<=`g`, `ack[g]`<=1, `ser_load`<=1, state<=LOAD.
  - If `ser_ready`=0, no grant is made, even with requests pending.
- **LOAD:** `ser_load` and `ack` are high for this single cycle. `req` is not sampled. Next state is GUARD.
- **GUARD:** one cycle, during which `ser_ready` is ignored; this covers serializer ready-deassert latency. The timer clears to 0. Next state is WAIT.
- **WAIT:** the timer increments every cycle.
  - If `ser_ready`=1: `done[owner]`<=1, `last`<=`owner`, state<=IDLE.
  - Else if timer = `TIMEOUT`-1: `err`<=1, `last`<=`owner`, state<=IDLE, and no `done` is pulsed.
- `ser_din` holds its value until the next grant.
- Requesters must keep `req`/`din` stable until they see `ack`. They may deassert `req` in the `ack` cycle. They may reassert `req` with a new word from the following cycle.
- Reset values (asynchronous, immediate on `rst_n`=0, including mid-transfer):
  - state=IDLE, all outputs 0: `ack`, `done`, `ser_din`, `ser_load`, `owner`, `busy`, `err`.
  - `last`=`NREQ`-1, so requester 0 has first priority after reset.
- Simultaneous events:
  - A `req` arriving in the same cycle that WAIT exits is not granted until the following IDLE cycle.
  - A `done` pulse and a new `ack` never occur in the same cycle.

## Timing
- Request sampled in IDLE at cycle N gives `ack`/`ser_load` at N+1 and GUARD at N+2. WAIT starts at N+3.
- `ser_ready` first sampled high in WAIT at cycle M gives `done` at M+1 and IDLE at M+1. The earliest next grant sample is M+1, so the earliest next `ser_load` is M+2.
- Minimum grant-to-grant period: 4 cycles plus the serializer busy time.
- Timeout declared exactly `TIMEOUT` WAIT cycles after WAIT entry; `err` rises on the following edge.
- All outputs are registered. There is no combinational path from `req` or `ser_ready` to any output.

## Structure
- Package `data8out_pkg`:
  - state enum (IDLE, LOAD, GUARD, WAIT);
  - default `WIDTH`=40;
  - `BYTES`=`WIDTH`/8.
- Sub-module `rr_picker` (combinational): inputs `req` and `last`; outputs `valid` and grant index `g`, using rotate-and-priority-encode.
- The top level holds the FSM, timer (clog2(`TIMEOUT`) bits), data/owner registers and output pulses.

## Test plan
Bench conditions: `NREQ`=4, `WIDTH`=40, `TIMEOUT`=64, serializer model deasserts ready 1 cycle after load and reasserts it 5 cycles later.
- **Single request:** `req[1]`=1 with `din[1]`=0x1255667890 → `ack[1]` and `ser_load` for one cycle, `ser_din`=0x1255667890, `owner`=1, `busy`=1; then `done[1]` one pulse after ready returns, `busy`=0.
- **All four at once:** all four `req` set simultaneously after reset, held until each ack → grant order 0,1,2,3, each with exactly one `ack` and one `done`.
- **Fairness:** `req[0]` and `req[2]` continuously reasserted → grants alternate 0,2,0,2; requesters 1 and 3 are never acked.
- **Timeout:** `ser_ready` stuck low after load → `err`=1 exactly 64 WAIT cycles after WAIT entry, no `done`, FSM in IDLE. Further `req` is not granted while `ser_ready`=0.
- **Reset mid-transfer:** `rst_n` pulsed low during WAIT → all outputs 0 immediately. After release, `req[3]` and `req[0]` both set → requester 0 granted first.
- **Ready gating:** `ser_ready`=0 in IDLE with `req[2]`=1 → no `ack`. Raising `ser_ready` → `ack[2]` the next cycle.
